// File: rtl/e1_pkg.sv
// Shared types and constants for the E1 CRC-4 multiframe alignment controller.
package e1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SRCH   = 2'd1,
    ST_LOCK   = 2'd2,
    ST_NONCRC = 2'd3
  } state_t;

  localparam int FR_PER_SEC  = 8000;  // frames per second (125 us frames)
  localparam int MFA_GAP     = 16;    // frames between consecutive MFA words
  localparam int T8_FR_DEF   = 64;
  localparam int T400_FR_DEF = 3200;
  localparam int EXC_THR_DEF = 915;

  localparam int ERR_W = 10;
  localparam int FC_W  = 13;
  localparam int GAP_W = 5;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  // saturating increment of the errored sub-multiframe count
  function automatic logic [ERR_W-1:0] err_add(input logic [ERR_W-1:0] c, input logic inc);
    return (inc && (c != ERR_MAX)) ? c + 1'b1 : c;
  endfunction

endpackage

// File: rtl/e1_frtimer.sv
// Frame timer: counts sof while enabled, wraps at TC and flags the terminal count.
module e1_frtimer #(
  parameter int W  = 8,
  parameter int TC = 256
) (
  input  logic clk2,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic sof,
  output logic tc
);

  localparam logic [W-1:0] LAST = W'(TC - 1);

  logic [W-1:0] cnt;
  logic         step;

  assign step = en & sof & ~clr;
  // tc fires on the sof that completes the TC-th counted frame
  assign tc   = step & (cnt == LAST);

  // qualified frame count, wraps so the timer is reusable as a free-running divider
  always_ff @(posedge clk2) begin
    if (rst || clr)  cnt <= '0;
    else if (step)   cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/e1_crc4_mfa_ctrl.sv
// E1 CRC-4 multiframe alignment controller: MFA search, lock, CRC-4 interworking
// fallback and per-second errored sub-multiframe monitoring.
module e1_crc4_mfa_ctrl
  import e1_pkg::*;
#(
  parameter int EXC_THR = EXC_THR_DEF,
  parameter int T8_FR   = T8_FR_DEF,
  parameter int T400_FR = T400_FR_DEF
) (
  input  logic             clk2,
  input  logic             rst,
  input  logic             sof,
  input  logic             infr,
  input  logic             smfdet,
  input  logic             crcerr,
  input  logic             losdet,
  output logic             reframe,
  output logic             crc4mode,
  output logic             mfalock,
  output logic [ERR_W-1:0] crcerrsec,
  output logic             secpls
);

  localparam int T8_W   = (T8_FR   > 1) ? $clog2(T8_FR)   : 1;
  localparam int T400_W = (T400_FR > 1) ? $clog2(T400_FR) : 1;

  localparam logic [GAP_W-1:0] GAP_V = GAP_W'(MFA_GAP);
  localparam logic [ERR_W-1:0] EXC_V = ERR_W'(EXC_THR);

  state_t             state, nstate;
  logic               armed, armed_n;
  logic [GAP_W-1:0]   gap, gap_n, gap_inc;
  logic               rf_n;
  logic               t8_clr, t8_tc;
  logic               t400_clr, t400_en, t400_tc;
  logic               sec_tc;
  logic [ERR_W-1:0]   err_cnt, err_close;
  logic               err_inc;

  // ---------------------------------------------------------------- timers
  assign t8_clr  = (state != ST_SRCH);
  assign t400_en = (state == ST_IDLE) || (state == ST_SRCH);

  e1_frtimer #(.W(T8_W), .TC(T8_FR)) u_t8 (
    .clk2 (clk2), .rst (rst), .clr (t8_clr), .en (1'b1), .sof (sof), .tc (t8_tc)
  );

  e1_frtimer #(.W(T400_W), .TC(T400_FR)) u_t400 (
    .clk2 (clk2), .rst (rst), .clr (t400_clr), .en (t400_en), .sof (sof), .tc (t400_tc)
  );

  e1_frtimer #(.W(FC_W), .TC(FR_PER_SEC)) u_sec (
    .clk2 (clk2), .rst (rst), .clr (1'b0), .en (1'b1), .sof (sof), .tc (sec_tc)
  );

  // ---------------------------------------------------------------- error count
  // a crcerr on the wrap cycle belongs to the second that is closing
  assign err_inc   = crcerr & (state == ST_LOCK);
  assign err_close = err_add(err_cnt, err_inc);

  // gap includes the current sof, so an smfdet 16 frames after the arming one sees 16
  assign gap_inc = (sof && (gap != '1)) ? gap + 1'b1 : gap;

  // ---------------------------------------------------------------- next state
  always_comb begin
    nstate   = state;
    armed_n  = armed;
    gap_n    = gap_inc;
    rf_n     = 1'b0;
    t400_clr = 1'b0;
    if (losdet) begin
      nstate   = ST_IDLE;
      t400_clr = 1'b1;
    end else if (!infr) begin
      nstate = ST_IDLE;
      if (state == ST_NONCRC) t400_clr = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (t400_tc) nstate = ST_NONCRC;
          else begin
            nstate  = ST_SRCH;
            armed_n = 1'b0;
            gap_n   = '0;
          end
        end
        ST_SRCH: begin
          if (t400_tc) nstate = ST_NONCRC;
          else if (smfdet && armed && (gap_inc == GAP_V)) begin
            nstate   = ST_LOCK;
            t400_clr = 1'b1;
          end else if (t8_tc) begin
            nstate = ST_IDLE;
            rf_n   = 1'b1;
          end else if (smfdet) begin
            armed_n = 1'b1;
            gap_n   = '0;
          end
        end
        ST_LOCK: begin
          if (sec_tc && (err_close >= EXC_V)) begin
            nstate = ST_IDLE;
            rf_n   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // state and alignment registers plus their registered outputs
  always_ff @(posedge clk2) begin
    if (rst) begin
      state    <= ST_IDLE;
      armed    <= 1'b0;
      gap      <= '0;
      reframe  <= 1'b0;
      crc4mode <= 1'b1;
      mfalock  <= 1'b0;
    end else begin
      state    <= nstate;
      armed    <= armed_n;
      gap      <= gap_n;
      reframe  <= rf_n & ~reframe;
      crc4mode <= (nstate != ST_NONCRC);
      mfalock  <= (nstate == ST_LOCK);
    end
  end

  // per-second error accumulation and snapshot
  always_ff @(posedge clk2) begin
    if (rst) begin
      err_cnt   <= '0;
      crcerrsec <= '0;
      secpls    <= 1'b0;
    end else begin
      secpls <= sec_tc;
      if (sec_tc) begin
        crcerrsec <= err_close;
        err_cnt   <= '0;
      end else begin
        err_cnt <= err_close;
      end
    end
  end

endmodule
